// File: rtl/cp0_unit_pkg.sv
// Shared CP0 constants: register indices, bit positions and FSM state encodings.
package cp0_unit_pkg;

  // CP0 register indices (rd field of MFC0/MTC0)
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EHBR   = 5'd15;

  // Bit positions inside STATUS and CAUSE
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_IP   = 10;

  // Redirect FSM state encodings
  localparam logic [1:0] CP0_IDLE = 2'd0;
  localparam logic [1:0] CP0_INT  = 2'd1;
  localparam logic [1:0] CP0_ERET = 2'd2;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: STATUS/CAUSE/EPC/EHBR register file, MFC0/MTC0 access,
// interrupt latching and the PC-redirect FSM for interrupt entry and ERET.
//
// Redirect handshake: jump_en is the valid, if_en is the ready. A redirect is
// transferred at a clock edge where jump_en & if_en are both high; until then
// jump_en and jump_addr are held stable and the FSM does not change state.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] EHBR_RST = 32'h0000_0010,
  parameter logic        IE_RST   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic        wen,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic        eret,
  input  logic        ir_en,
  input  logic        ir_in,
  input  logic [31:0] ret_addr,
  input  logic        if_en,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic [1:0]  dbg_state
);

  logic [1:0]  state_q, state_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic        ip_q, ip_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ehbr_q, ehbr_d;
  logic        take_int;
  logic        int_ok;

  // MFC0 read port: current register values, no bypass of a same-cycle MTC0
  always_comb begin
    data_r = 32'd0;
    case (addr_r)
      CP0_STATUS: begin
        data_r[STATUS_IE]  = ie_q;
        data_r[STATUS_EXL] = exl_q;
      end
      CP0_CAUSE:  data_r[CAUSE_IP] = ip_q;
      CP0_EPC:    data_r = epc_q;
      CP0_EHBR:   data_r = ehbr_q;
      default:    data_r = 32'd0;
    endcase
  end

  // Redirect outputs decoded from the FSM state
  always_comb begin
    jump_en   = (state_q != CP0_IDLE);
    jump_addr = 32'd0;
    case (state_q)
      CP0_INT:  jump_addr = ehbr_q;
      CP0_ERET: jump_addr = epc_q;
      default:  jump_addr = 32'd0;
    endcase
  end

  assign dbg_state = state_q;

  // Next-state logic: MTC0 writes first, then FSM side effects override them
  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    exl_d   = exl_q;
    epc_d   = epc_q;
    ehbr_d  = ehbr_q;

    take_int = (state_q == CP0_INT) && if_en;
    // A level still high at the accepting edge re-arms IP so it is not lost.
    ip_d     = (ip_q & ~take_int) | ir_in;
    // Interrupt qualification apart from EXL, on the next-state IP so a pulse
    // sampled at this edge already raises the request.
    int_ok   = ip_d & ie_q & ir_en;

    if (wen) begin
      case (addr_w)
        CP0_STATUS: begin
          ie_d  = data_w[STATUS_IE];
          exl_d = data_w[STATUS_EXL];
        end
        CP0_EPC:  epc_d  = data_w;
        CP0_EHBR: ehbr_d = data_w;
        default:  ;
      endcase
    end

    case (state_q)
      CP0_IDLE: begin
        if (eret) begin
          state_d = CP0_ERET;
        end else if (int_ok && !exl_q) begin
          state_d = CP0_INT;
        end
      end
      CP0_INT: begin
        if (if_en) begin
          epc_d   = ret_addr;
          exl_d   = 1'b1;
          state_d = CP0_IDLE;
        end
      end
      CP0_ERET: begin
        if (if_en) begin
          exl_d   = 1'b0;
          // EXL drops here, so an interrupt held back by the handler is
          // issued straight away and the two redirects run back to back.
          state_d = int_ok ? CP0_INT : CP0_IDLE;
        end
      end
      default: state_d = CP0_IDLE;
    endcase
  end

  // State and register update; reset aborts any pending redirect immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CP0_IDLE;
      ie_q    <= IE_RST;
      exl_q   <= 1'b0;
      ip_q    <= 1'b0;
      epc_q   <= 32'd0;
      ehbr_q  <= EHBR_RST;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      ip_q    <= ip_d;
      epc_q   <= epc_d;
      ehbr_q  <= ehbr_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed testbench for cp0_unit: register access, interrupt entry, stalled
// accept, nesting through ERET, ERET/interrupt priority and asynchronous reset.
module tb_cp0_unit;
  import cp0_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic        wen;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic        eret;
  logic        ir_en;
  logic        ir_in;
  logic [31:0] ret_addr;
  logic        if_en;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  cp0_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_r    (addr_r),
    .data_r    (data_r),
    .wen       (wen),
    .addr_w    (addr_w),
    .data_w    (data_w),
    .eret      (eret),
    .ir_en     (ir_en),
    .ir_in     (ir_in),
    .ret_addr  (ret_addr),
    .if_en     (if_en),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .dbg_state (dbg_state)
  );

  // Clock: 20 ns period
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the MFC0 index, let data_r settle, compare
  task automatic chk_rd(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    addr_r = idx;
    #1;
    chk(tag, data_r, exp);
  endtask

  // Advance past the next active edge; inputs are changed right after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_jump(input string tag, input logic en, input logic [31:0] addr);
    #1;
    chk({tag, "_en"}, {31'd0, jump_en}, {31'd0, en});
    chk({tag, "_addr"}, jump_addr, addr);
  endtask

  initial begin
    rst_n    = 1'b0;
    addr_r   = 5'd0;
    wen      = 1'b0;
    addr_w   = 5'd0;
    data_w   = 32'd0;
    eret     = 1'b0;
    ir_en    = 1'b0;
    ir_in    = 1'b0;
    ret_addr = 32'd0;
    if_en    = 1'b1;

    // Reset state
    #15;
    chk_jump("rst", 1'b0, 32'd0);
    chk_rd("rst_ehbr", CP0_EHBR, 32'h10);
    chk_rd("rst_status", CP0_STATUS, 32'd0);
    chk_rd("rst_epc", CP0_EPC, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, CP0_IDLE});
    #20;
    rst_n = 1'b1;
    tick();

    // 1: MTC0/MFC0, no write bypass, unused index and read-only CAUSE
    wen = 1'b1; addr_w = CP0_EHBR; data_w = 32'h100;
    chk_rd("ehbr_no_bypass", CP0_EHBR, 32'h10);
    tick();
    wen = 1'b0;
    chk_rd("ehbr_written", CP0_EHBR, 32'h100);
    chk_rd("idx3_zero", 5'd3, 32'd0);
    wen = 1'b1; addr_w = CP0_CAUSE; data_w = 32'hFFFF_FFFF;
    tick();
    addr_w = 5'd3; data_w = 32'hA5A5_A5A5;
    tick();
    wen = 1'b0;
    chk_rd("cause_ro", CP0_CAUSE, 32'd0);
    chk_rd("idx3_ignore", 5'd3, 32'd0);
    wen = 1'b1; addr_w = CP0_STATUS; data_w = 32'h1;
    tick();
    wen = 1'b0;
    chk_rd("status_ie", CP0_STATUS, 32'h1);

    // 2: interrupt entry with immediate accept
    ir_en = 1'b1; ret_addr = 32'h40; if_en = 1'b1;
    ir_in = 1'b1;
    tick();
    ir_in = 1'b0;
    chk_jump("int_req", 1'b1, 32'h100);
    chk_rd("int_ip_set", CP0_CAUSE, 32'h400);
    tick();
    chk_jump("int_done", 1'b0, 32'd0);
    chk_rd("int_epc", CP0_EPC, 32'h40);
    chk_rd("int_status", CP0_STATUS, 32'h3);
    chk_rd("int_ip_clr", CP0_CAUSE, 32'd0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk_jump("eret_req", 1'b1, 32'h40);
    tick();
    chk_jump("eret_done", 1'b0, 32'd0);
    chk_rd("eret_status", CP0_STATUS, 32'h1);

    // 3: stalled accept, EPC sampled only at the accepting edge, beats MTC0 EPC
    if_en = 1'b0; ir_in = 1'b1;
    tick();
    ir_in = 1'b0; ret_addr = 32'h44;
    chk_jump("stall1", 1'b1, 32'h100);
    tick();
    ret_addr = 32'h48;
    chk_jump("stall2", 1'b1, 32'h100);
    tick();
    chk_jump("stall3", 1'b1, 32'h100);
    chk_rd("stall_epc", CP0_EPC, 32'h40);
    if_en = 1'b1; ret_addr = 32'h4C;
    wen = 1'b1; addr_w = CP0_EPC; data_w = 32'hDEAD_BEEF;
    tick();
    wen = 1'b0;
    chk_jump("stall_done", 1'b0, 32'd0);
    chk_rd("stall_epc_cap", CP0_EPC, 32'h4C);

    // 4: EXL masks, ERET then back-to-back interrupt redirect
    ir_in = 1'b1;
    tick();
    ir_in = 1'b0;
    chk_jump("masked", 1'b0, 32'd0);
    chk_rd("masked_ip", CP0_CAUSE, 32'h400);
    tick();
    chk_jump("masked2", 1'b0, 32'd0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk_jump("nest_eret", 1'b1, 32'h4C);
    ret_addr = 32'h80;
    tick();
    chk_jump("nest_int", 1'b1, 32'h100);
    chk_rd("nest_exl0", CP0_STATUS, 32'h1);
    tick();
    chk_jump("nest_done", 1'b0, 32'd0);
    chk_rd("nest_epc", CP0_EPC, 32'h80);
    chk_rd("nest_status", CP0_STATUS, 32'h3);

    // 5: ERET wins over a same-cycle interrupt, interrupt follows
    wen = 1'b1; addr_w = CP0_STATUS; data_w = 32'h1;
    tick();
    wen = 1'b0;
    eret = 1'b1; ir_in = 1'b1;
    tick();
    eret = 1'b0; ir_in = 1'b0;
    chk_jump("prio_eret", 1'b1, 32'h80);
    ret_addr = 32'h90;
    tick();
    chk_jump("prio_int", 1'b1, 32'h100);
    tick();
    chk_jump("prio_done", 1'b0, 32'd0);
    chk_rd("prio_epc", CP0_EPC, 32'h90);

    // 6: clearing IE/ir_en keeps a pending request; async reset aborts it
    wen = 1'b1; addr_w = CP0_STATUS; data_w = 32'h1;
    tick();
    wen = 1'b0;
    if_en = 1'b0; ir_in = 1'b1;
    tick();
    ir_in = 1'b0;
    wen = 1'b1; addr_w = CP0_STATUS; data_w = 32'h0; ir_en = 1'b0;
    tick();
    wen = 1'b0;
    chk_jump("keep_req", 1'b1, 32'h100);
    chk_rd("keep_status", CP0_STATUS, 32'h0);
    rst_n = 1'b0;
    chk_jump("async_rst", 1'b0, 32'd0);
    chk_rd("async_ehbr", CP0_EHBR, 32'h10);
    chk_rd("async_epc", CP0_EPC, 32'd0);
    chk("async_state", {30'd0, dbg_state}, {30'd0, CP0_IDLE});
    #20;
    rst_n = 1'b1; if_en = 1'b1;
    tick();
    chk_jump("post_rst", 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
